core_nios2_oci_dct_ctrl: RTL

Sequencer for the OCI data-capture-trace (DCT) packing path. It accepts 2-bit trace atoms from the trace source over a valid/ready handshake and packs them into a 30-bit DCT buffer. It hands completed frames (buffer plus atom count) to the downstream trace FIFO on full, on flush, on idle timeout or on trace disable. It sits between the OCI trace-atom generator and the trace memory/JTAG drain, and exposes its live accumulator (`dct_buffer`, `dct_count`) for the simulation test bench.

---
 rtl/core_nios2_oci_dct_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/core_nios2_oci_dct_ctrl.sv
// OCI data-capture-trace sequencer: packs 2-bit trace atoms into a 30-bit DCT
// frame and hands frames to the trace FIFO on full, flush, idle timeout or disable.
module core_nios2_oci_dct_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        flush,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [29:0] frm_buffer,
  output logic [3:0]  frm_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        idle
);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } occ_t;

  localparam logic [8:0] TMO = 9'(TIMEOUT);

  occ_t        occ;
  logic        flush_pend;
  logic [7:0]  idle_cnt;
  logic        timeout_hit;
  logic        out_free;
  logic        xfer;
  logic        accept;
  logic [29:0] buf_ins;

  always_comb begin
    if (dct_count == 4'd0)
      occ = EMPTY;
    else if (dct_count == 4'd15)
      occ = FULL;
    else
      occ = FILL;

    // idle_cnt + 1 > TMO is idle_cnt >= TMO without a constant compare when TMO is 0
    timeout_hit = (TMO != 9'd0) && (({1'b0, idle_cnt} + 9'd1) > TMO);
    out_free    = !frm_valid || frm_ready;
    // A flush pulse takes effect in its own cycle, not only once registered
    xfer        = (occ != EMPTY) && out_free &&
                  ((occ == FULL) || flush_pend || flush || timeout_hit || !trace_enable);
    atom_ready  = trace_enable && ((occ != FULL) || xfer);
    accept      = atom_valid && atom_ready;
    idle        = (occ == EMPTY) && !frm_valid && !flush_pend;
    buf_ins     = dct_buffer | (30'(atom_data) << {dct_count, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frm_valid  <= 1'b0;
      frm_buffer <= '0;
      frm_count  <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      if (xfer) begin
        frm_valid  <= 1'b1;
        frm_buffer <= dct_buffer;
        frm_count  <= dct_count;
      end else if (frm_ready) begin
        frm_valid  <= 1'b0;
      end

      // An atom accepted alongside an xfer starts the next frame in slot 0
      if (xfer) begin
        dct_buffer <= accept ? {28'd0, atom_data} : '0;
        dct_count  <= accept ? 4'd1 : 4'd0;
      end else if (accept) begin
        dct_buffer <= buf_ins;
        dct_count  <= dct_count + 4'd1;
      end

      if (xfer || ((occ == EMPTY) && !accept))
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;

      if (accept || xfer)
        idle_cnt <= '0;
      else if ((occ != EMPTY) && (idle_cnt != 8'hFF))
        idle_cnt <= idle_cnt + 8'd1;
    end
  end

endmodule
